// File: rtl/systolic_result_drain.sv
// Result drain for the systolic MAC array: snapshots the N*N result matrix on a
// completion edge and streams it row-major over valid/ready with a last marker.
module systolic_result_drain #(
    parameter int N      = 4,
    parameter int ELEM_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N*N*ELEM_W-1:0]      y_in,
    input  logic                       res_valid,
    output logic [ELEM_W-1:0]          out_data,
    output logic [$clog2(N)-1:0]       out_row,
    output logic [$clog2(N)-1:0]       out_col,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic [CNT_W-1:0]           frame_cnt
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int RC_W  = $clog2(N);

    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_res_valid_q;
    logic [ELEM_W-1:0] r_buf [NN];

    logic              w_evt;
    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_drop;
    logic [IDX_W-1:0]  w_idx_inc;

    // Edge detect on the completion level and transfer qualification.
    always_comb begin
        w_evt       = res_valid & ~r_res_valid_q;
        w_xfer      = (r_state == DRAIN) & out_ready;
        w_last_xfer = w_xfer & (r_idx == IDX_W'(NN - 1));
        w_drop      = w_evt & (r_state == DRAIN) & ~w_last_xfer;
        w_idx_inc   = r_idx + IDX_W'(1);
    end

    // Drain FSM; every output is registered so the beat for the next index is
    // prepared one cycle ahead, including element 0 straight from y_in on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_res_valid_q <= 1'b0;
            out_data      <= '0;
            out_row       <= '0;
            out_col       <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            frame_cnt     <= '0;
            for (int k = 0; k < NN; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_res_valid_q <= res_valid;
            frame_done    <= 1'b0;

            // A drop beats a simultaneous clear so no event loss goes unreported.
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_evt) begin
                        for (int k = 0; k < NN; k++) begin
                            r_buf[k] <= y_in[(NN-1-k)*ELEM_W +: ELEM_W];
                        end
                        r_state   <= DRAIN;
                        r_idx     <= '0;
                        out_data  <= y_in[NN*ELEM_W-1 -: ELEM_W];
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_last_xfer) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        r_idx      <= '0;
                        out_row    <= '0;
                        out_col    <= '0;
                        out_last   <= 1'b0;
                        if (w_evt) begin
                            for (int k = 0; k < NN; k++) begin
                                r_buf[k] <= y_in[(NN-1-k)*ELEM_W +: ELEM_W];
                            end
                            out_data <= y_in[NN*ELEM_W-1 -: ELEM_W];
                        end else begin
                            r_state   <= IDLE;
                            out_data  <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else if (w_xfer) begin
                        r_idx    <= w_idx_inc;
                        out_data <= r_buf[w_idx_inc];
                        out_row  <= RC_W'(w_idx_inc / IDX_W'(N));
                        out_col  <= RC_W'(w_idx_inc % IDX_W'(N));
                        out_last <= (w_idx_inc == IDX_W'(NN - 1));
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_idx     <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
